pipeline_stall_controller: RTL and testbench

//  Central hazard/stall sequencer for the 5-stage pipeline. Drives hold enables and

---
 rtl/pipeline_stall_controller.sv | 174 +++++++++++++++++
 tb/tb_pipeline_stall_controller.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_controller.sv
// ----------------------------------------------------------------------------
// pipeline_stall_controller
//
// Hazard/stall sequencer for the 5-stage pipeline. It produces the hold
// enables and bubble/flush controls for the PC, IF/ID, ID/EX, EX/MEM and
// MEM/WB registers. It resolves load-use hazards, taken-branch flushes and
// multi-cycle data-memory waits. A watchdog bounds memory waits, and a
// saturating counter records stalled cycles.
//
// Parameters
//   MEM_TIMEOUT  consecutive frozen memory cycles before the watchdog trips
//                (legal range 2..255)
//   REG_W        register-address width
//
// Ports
//   clock, reset                  rising-edge clock; asynchronous active-high reset
//   ID_rs, ID_rt, ID_uses_rt      source registers of the ID instruction
//   EX_write_reg_1                destination register of the EX instruction
//   EX_rm_write_enable            EX instruction writes the register file
//   EX_rm_write_data_source       EX instruction is a load
//   EX_branch_taken               branch in EX resolved taken
//   MEM_dm_access, dm_ready       MEM data-memory access and its acknowledge
//   pc_enable .. MEM_WB_bubble    pipeline register controls (combinational)
//   mem_timeout_error             sticky watchdog flag
//   stall_count                   saturating count of cycles with pc_enable=0
// ----------------------------------------------------------------------------
module pipeline_stall_controller #(
    parameter int MEM_TIMEOUT = 16,
    parameter int REG_W       = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [REG_W-1:0] ID_rs,
    input  logic [REG_W-1:0] ID_rt,
    input  logic             ID_uses_rt,
    input  logic [REG_W-1:0] EX_write_reg_1,
    input  logic             EX_rm_write_enable,
    input  logic             EX_rm_write_data_source,
    input  logic             EX_branch_taken,
    input  logic             MEM_dm_access,
    input  logic             dm_ready,
    output logic             pc_enable,
    output logic             IF_ID_enable,
    output logic             IF_ID_flush,
    output logic             ID_EX_enable,
    output logic             ID_EX_bubble,
    output logic             EX_MEM_enable,
    output logic             MEM_WB_bubble,
    output logic             mem_timeout_error,
    output logic [15:0]      stall_count
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [15:0] stall_count_q;
    logic        load_use;
    logic        run_controls;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        if (value == 16'hFFFF) begin
            return value;
        end
        return value + 16'd1;
    endfunction

    // r0 is hardwired to zero, so a load into it never creates a dependency.
    assign load_use = EX_rm_write_enable && EX_rm_write_data_source &&
                      (EX_write_reg_1 != '0) &&
                      ((EX_write_reg_1 == ID_rs) ||
                       (ID_uses_rt && (EX_write_reg_1 == ID_rt)));

    always_comb begin
        state_d           = state_q;
        wait_cnt_d        = wait_cnt_q;
        run_controls      = 1'b0;
        pc_enable         = 1'b0;
        IF_ID_enable      = 1'b0;
        IF_ID_flush       = 1'b0;
        ID_EX_enable      = 1'b0;
        ID_EX_bubble      = 1'b0;
        EX_MEM_enable     = 1'b0;
        MEM_WB_bubble     = 1'b0;
        mem_timeout_error = 1'b0;

        unique case (state_q)
            RUN: begin
                if (MEM_dm_access && !dm_ready) begin
                    // Freeze everything upstream of MEM and push a NOP into WB.
                    MEM_WB_bubble = 1'b1;
                    state_d       = MEM_WAIT;
                    wait_cnt_d    = 8'd1;
                end else begin
                    run_controls = 1'b1;
                    wait_cnt_d   = 8'd0;
                end
            end
            MEM_WAIT: begin
                if (!dm_ready) begin
                    MEM_WB_bubble = 1'b1;
                    wait_cnt_d    = wait_cnt_q + 8'd1;
                    if (wait_cnt_q == WAIT_LAST) begin
                        state_d = ERROR;
                    end
                end else begin
                    // Release cycle behaves like RUN, so deferred hazards resolve now.
                    run_controls = 1'b1;
                    state_d      = RUN;
                    wait_cnt_d   = 8'd0;
                end
            end
            ERROR: begin
                MEM_WB_bubble     = 1'b1;
                mem_timeout_error = 1'b1;
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = 8'd0;
            end
        endcase

        if (run_controls) begin
            pc_enable     = 1'b1;
            IF_ID_enable  = 1'b1;
            ID_EX_enable  = 1'b1;
            EX_MEM_enable = 1'b1;
            if (EX_branch_taken) begin
                // The ID instruction is squashed, so its load-use hazard is moot.
                IF_ID_flush  = 1'b1;
                ID_EX_bubble = 1'b1;
            end else if (load_use) begin
                pc_enable    = 1'b0;
                IF_ID_enable = 1'b0;
                ID_EX_bubble = 1'b1;
            end
        end

        // Hold the whole pipeline frozen while reset is asserted.
        if (reset) begin
            pc_enable         = 1'b0;
            IF_ID_enable      = 1'b0;
            IF_ID_flush       = 1'b0;
            ID_EX_enable      = 1'b0;
            ID_EX_bubble      = 1'b0;
            EX_MEM_enable     = 1'b0;
            MEM_WB_bubble     = 1'b0;
            mem_timeout_error = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= RUN;
            wait_cnt_q    <= 8'd0;
            stall_count_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if (!pc_enable) begin
                stall_count_q <= sat_inc16(stall_count_q);
            end
        end
    end

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
module tb_pipeline_stall_controller;

    logic        clock;
    logic        reset;
    logic [4:0]  ID_rs;
    logic [4:0]  ID_rt;
    logic        ID_uses_rt;
    logic [4:0]  EX_write_reg_1;
    logic        EX_rm_write_enable;
    logic        EX_rm_write_data_source;
    logic        EX_branch_taken;
    logic        MEM_dm_access;
    logic        dm_ready;
    logic        pc_enable;
    logic        IF_ID_enable;
    logic        IF_ID_flush;
    logic        ID_EX_enable;
    logic        ID_EX_bubble;
    logic        EX_MEM_enable;
    logic        MEM_WB_bubble;
    logic        mem_timeout_error;
    logic [15:0] stall_count;

    int checks = 0;
    int passed = 0;

    // {pc_en, IF_ID_en, IF_ID_flush, ID_EX_en, ID_EX_bubble, EX_MEM_en, MEM_WB_bubble, error}
    logic [7:0] outs;
    assign outs = {pc_enable, IF_ID_enable, IF_ID_flush, ID_EX_enable,
                   ID_EX_bubble, EX_MEM_enable, MEM_WB_bubble, mem_timeout_error};

    localparam logic [7:0] O_ZERO    = 8'b0000_0000;
    localparam logic [7:0] O_NORMAL  = 8'b1101_0100;
    localparam logic [7:0] O_LOADUSE = 8'b0001_1100;
    localparam logic [7:0] O_BRANCH  = 8'b1111_1100;
    localparam logic [7:0] O_FREEZE  = 8'b0000_0010;
    localparam logic [7:0] O_ERROR   = 8'b0000_0011;

    pipeline_stall_controller #(
        .MEM_TIMEOUT(4),
        .REG_W(5)
    ) dut (
        .clock(clock),
        .reset(reset),
        .ID_rs(ID_rs),
        .ID_rt(ID_rt),
        .ID_uses_rt(ID_uses_rt),
        .EX_write_reg_1(EX_write_reg_1),
        .EX_rm_write_enable(EX_rm_write_enable),
        .EX_rm_write_data_source(EX_rm_write_data_source),
        .EX_branch_taken(EX_branch_taken),
        .MEM_dm_access(MEM_dm_access),
        .dm_ready(dm_ready),
        .pc_enable(pc_enable),
        .IF_ID_enable(IF_ID_enable),
        .IF_ID_flush(IF_ID_flush),
        .ID_EX_enable(ID_EX_enable),
        .ID_EX_bubble(ID_EX_bubble),
        .EX_MEM_enable(EX_MEM_enable),
        .MEM_WB_bubble(MEM_WB_bubble),
        .mem_timeout_error(mem_timeout_error),
        .stall_count(stall_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic set_idle();
        ID_rs                   = 5'd0;
        ID_rt                   = 5'd0;
        ID_uses_rt              = 1'b0;
        EX_write_reg_1          = 5'd0;
        EX_rm_write_enable      = 1'b0;
        EX_rm_write_data_source = 1'b0;
        EX_branch_taken         = 1'b0;
        MEM_dm_access           = 1'b0;
        dm_ready                = 1'b1;
    endtask

    task automatic set_load(input logic [4:0] rd);
        EX_write_reg_1          = rd;
        EX_rm_write_enable      = 1'b1;
        EX_rm_write_data_source = 1'b1;
    endtask

    task automatic apply_reset();
        @(negedge clock);
        set_idle();
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clock);
        set_idle();
        reset = 1'b1;
        #1;
        checks++;
        if (outs !== O_ZERO) $display("FAIL reset_outputs got %b want %b", outs, O_ZERO);
        else passed++;
        checks++;
        if (stall_count !== 16'd0) $display("FAIL reset_stall_count got %0d want 0", stall_count);
        else passed++;
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (outs !== O_NORMAL) $display("FAIL idle_outputs[%0d] got %b want %b", i, outs, O_NORMAL);
            else passed++;
            @(negedge clock);
        end
        checks++;
        if (stall_count !== 16'd0) $display("FAIL idle_stall_count got %0d want 0", stall_count);
        else passed++;
    endtask

    task automatic test_load_use();
        apply_reset();
        set_load(5'd5);
        ID_rs = 5'd5;
        #1;
        checks++;
        if (outs !== O_LOADUSE) $display("FAIL load_use_rs got %b want %b", outs, O_LOADUSE);
        else passed++;
        @(negedge clock);
        set_idle();
        #1;
        checks++;
        if (outs !== O_NORMAL) $display("FAIL load_use_after got %b want %b", outs, O_NORMAL);
        else passed++;
        checks++;
        if (stall_count !== 16'd1) $display("FAIL load_use_stall_count got %0d want 1", stall_count);
        else passed++;
        // Match through rt only when the ID instruction actually reads rt.
        @(negedge clock);
        set_load(5'd7);
        ID_rs      = 5'd3;
        ID_rt      = 5'd7;
        ID_uses_rt = 1'b1;
        #1;
        checks++;
        if (outs !== O_LOADUSE) $display("FAIL load_use_rt got %b want %b", outs, O_LOADUSE);
        else passed++;
        @(negedge clock);
        ID_uses_rt = 1'b0;
        #1;
        checks++;
        if (outs !== O_NORMAL) $display("FAIL load_use_rt_unused got %b want %b", outs, O_NORMAL);
        else passed++;
        @(negedge clock);
        set_idle();
        checks++;
        if (stall_count !== 16'd2) $display("FAIL load_use_rt_stall_count got %0d want 2", stall_count);
        else passed++;
    endtask

    task automatic test_no_stall();
        apply_reset();
        set_load(5'd0);
        ID_rs = 5'd0;
        #1;
        checks++;
        if (outs !== O_NORMAL) $display("FAIL no_stall_r0 got %b want %b", outs, O_NORMAL);
        else passed++;
        @(negedge clock);
        set_load(5'd5);
        EX_rm_write_data_source = 1'b0;
        ID_rs = 5'd5;
        #1;
        checks++;
        if (outs !== O_NORMAL) $display("FAIL no_stall_alu got %b want %b", outs, O_NORMAL);
        else passed++;
        @(negedge clock);
        set_idle();
        checks++;
        if (stall_count !== 16'd0) $display("FAIL no_stall_count got %0d want 0", stall_count);
        else passed++;
    endtask

    task automatic test_branch();
        apply_reset();
        set_load(5'd9);
        ID_rs           = 5'd9;
        EX_branch_taken = 1'b1;
        #1;
        checks++;
        if (outs !== O_BRANCH) $display("FAIL branch_plus_load_use got %b want %b", outs, O_BRANCH);
        else passed++;
        @(negedge clock);
        set_idle();
        #1;
        checks++;
        if (outs !== O_NORMAL) $display("FAIL branch_after got %b want %b", outs, O_NORMAL);
        else passed++;
        checks++;
        if (stall_count !== 16'd0) $display("FAIL branch_stall_count got %0d want 0", stall_count);
        else passed++;
    endtask

    task automatic test_mem_wait();
        apply_reset();
        MEM_dm_access   = 1'b1;
        dm_ready        = 1'b0;
        EX_branch_taken = 1'b1;
        // Cycle 1: branch plus memory wait must freeze only.
        #1;
        checks++;
        if (outs !== O_FREEZE) $display("FAIL mem_wait_c1_branch got %b want %b", outs, O_FREEZE);
        else passed++;
        @(negedge clock);
        #1;
        checks++;
        if (outs !== O_FREEZE) $display("FAIL mem_wait_c2_branch got %b want %b", outs, O_FREEZE);
        else passed++;
        @(negedge clock);
        EX_branch_taken = 1'b0;
        set_load(5'd4);
        ID_rs = 5'd4;
        #1;
        checks++;
        if (outs !== O_FREEZE) $display("FAIL mem_wait_c3_load_use got %b want %b", outs, O_FREEZE);
        else passed++;
        @(negedge clock);
        // Release: the branch is re-evaluated and wins over the load-use.
        dm_ready        = 1'b1;
        EX_branch_taken = 1'b1;
        #1;
        checks++;
        if (outs !== O_BRANCH) $display("FAIL mem_wait_release got %b want %b", outs, O_BRANCH);
        else passed++;
        @(negedge clock);
        set_idle();
        #1;
        checks++;
        if (outs !== O_NORMAL) $display("FAIL mem_wait_after got %b want %b", outs, O_NORMAL);
        else passed++;
        checks++;
        if (stall_count !== 16'd3) $display("FAIL mem_wait_stall_count got %0d want 3", stall_count);
        else passed++;
    endtask

    task automatic test_timeout();
        apply_reset();
        MEM_dm_access = 1'b1;
        dm_ready      = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (outs !== O_FREEZE) $display("FAIL timeout_freeze[%0d] got %b want %b", i, outs, O_FREEZE);
            else passed++;
            @(negedge clock);
        end
        #1;
        checks++;
        if (outs !== O_ERROR) $display("FAIL timeout_error got %b want %b", outs, O_ERROR);
        else passed++;
        @(negedge clock);
        set_idle();
        #1;
        checks++;
        if (outs !== O_ERROR) $display("FAIL timeout_sticky got %b want %b", outs, O_ERROR);
        else passed++;
        @(negedge clock);
        checks++;
        if (stall_count !== 16'd6) $display("FAIL timeout_stall_count got %0d want 6", stall_count);
        else passed++;
        // Asynchronous reset in mid-cycle clears everything at once.
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (outs !== O_ZERO) $display("FAIL timeout_async_reset got %b want %b", outs, O_ZERO);
        else passed++;
        checks++;
        if (stall_count !== 16'd0) $display("FAIL timeout_reset_count got %0d want 0", stall_count);
        else passed++;
        @(negedge clock);
        reset = 1'b0;
        #1;
        checks++;
        if (outs !== O_NORMAL) $display("FAIL timeout_recovered got %b want %b", outs, O_NORMAL);
        else passed++;
    endtask

    task automatic test_reset_mid_wait();
        apply_reset();
        MEM_dm_access = 1'b1;
        dm_ready      = 1'b0;
        @(negedge clock);
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (outs !== O_ZERO) $display("FAIL mid_wait_reset got %b want %b", outs, O_ZERO);
        else passed++;
        @(negedge clock);
        reset = 1'b0;
        set_idle();
        #1;
        checks++;
        if (outs !== O_NORMAL) $display("FAIL mid_wait_after_reset got %b want %b", outs, O_NORMAL);
        else passed++;
        // A fresh wait must again take four frozen cycles before the watchdog trips.
        @(negedge clock);
        MEM_dm_access = 1'b1;
        dm_ready      = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (outs !== O_FREEZE) $display("FAIL mid_wait_refreeze[%0d] got %b want %b", i, outs, O_FREEZE);
            else passed++;
            @(negedge clock);
        end
        #1;
        checks++;
        if (outs !== O_ERROR) $display("FAIL mid_wait_retrip got %b want %b", outs, O_ERROR);
        else passed++;
    endtask

    initial begin
        reset = 1'b1;
        set_idle();
        test_reset();
        test_load_use();
        test_no_stall();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog_timeout got no_finish want finish");
        $fatal(1, "simulation time limit");
    end

endmodule
